// File: rtl/loop_seq_ctrl.sv
// loop_seq_ctrl: sequencer for three nested loop counters (I outer, J, K inner).
// Clears and increments external counters via one-cycle strobes, samples their
// z flags (limit > count) after a settle delay, and hands one body_req/body_ack
// handshake to the datapath per innermost iteration.
//
// Ports:
//   Clk, RST              clock, asynchronous active-high reset
//   start, abort          begin a run (IDLE only) / synchronous abort to IDLE
//   z_i, z_j, z_k         counter "loop continues" flags
//   rst_i/j/k, inc_i/j/k  one-cycle clear / increment strobes to the counters
//   body_req, body_ack    per-body handshake with the datapath
//   busy, done            not-IDLE indicator / one-cycle end-of-run pulse
//   body_cnt              bodies completed in the current run (wrapping)
module loop_seq_ctrl #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 12
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic             z_i,
  input  logic             z_j,
  input  logic             z_k,
  input  logic             body_ack,
  output logic             rst_i,
  output logic             rst_j,
  output logic             rst_k,
  output logic             inc_i,
  output logic             inc_j,
  output logic             inc_k,
  output logic             body_req,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] body_cnt
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT, CHK_I, CHK_J, CHK_K, BODY, ADV_K, ADV_J, ADV_I, DONE
  } state_t;

  state_t            state, state_d;
  state_t            ret, ret_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic [CNT_W-1:0]  cnt_d;

  // Next-state, settle-return bookkeeping and body counter update
  always_comb begin
    state_d = state;
    ret_d   = ret;
    wait_d  = wait_cnt;
    cnt_d   = body_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      INIT: begin
        state_d = WAIT;
        ret_d   = CHK_I;
        wait_d  = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_cnt == '0) state_d = ret;
        else                wait_d  = wait_cnt - WAIT_W'(1);
      end
      CHK_I: state_d = z_i ? CHK_J : DONE;
      CHK_J: state_d = z_j ? CHK_K : ADV_I;
      CHK_K: state_d = z_k ? BODY  : ADV_J;
      BODY: begin
        if (body_ack) begin
          state_d = ADV_K;
          cnt_d   = body_cnt + CNT_W'(1);
        end
      end
      ADV_K: begin
        state_d = WAIT;
        ret_d   = CHK_K;
        wait_d  = WAIT_LOAD;
      end
      ADV_J: begin
        state_d = WAIT;
        ret_d   = CHK_J;
        wait_d  = WAIT_LOAD;
      end
      ADV_I: begin
        state_d = WAIT;
        ret_d   = CHK_I;
        wait_d  = WAIT_LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition and freezes the body count
    if (abort) begin
      state_d = IDLE;
      cnt_d   = body_cnt;
    end
  end

  // State register; outputs are the state decode, registered from state_d so
  // they line up with the state they belong to
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ret      <= IDLE;
      wait_cnt <= '0;
      body_cnt <= '0;
      rst_i    <= 1'b0;
      rst_j    <= 1'b0;
      rst_k    <= 1'b0;
      inc_i    <= 1'b0;
      inc_j    <= 1'b0;
      inc_k    <= 1'b0;
      body_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      ret      <= ret_d;
      wait_cnt <= wait_d;
      body_cnt <= cnt_d;
      rst_i    <= (state_d == INIT);
      rst_j    <= (state_d == INIT) || (state_d == ADV_I);
      rst_k    <= (state_d == INIT) || (state_d == ADV_I) || (state_d == ADV_J);
      inc_i    <= (state_d == ADV_I);
      inc_j    <= (state_d == ADV_J);
      inc_k    <= (state_d == ADV_K);
      body_req <= (state_d == BODY);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_loop_seq_ctrl.sv
// Bench for loop_seq_ctrl: behavioural loop counters, random ack delays, and a
// scoreboard of expected body counts and per-run strobe totals.
module tb_loop_seq_ctrl;

  localparam int unsigned CNT_W = 12;

  logic             Clk = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             z_i, z_j, z_k;
  logic             body_ack = 1'b0;
  logic             rst_i, rst_j, rst_k, inc_i, inc_j, inc_k;
  logic             body_req, busy, done;
  logic [CNT_W-1:0] body_cnt;

  loop_seq_ctrl #(.SETTLE(1), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .RST(RST), .start(start), .abort(abort),
    .z_i(z_i), .z_j(z_j), .z_k(z_k), .body_ack(body_ack),
    .rst_i(rst_i), .rst_j(rst_j), .rst_k(rst_k),
    .inc_i(inc_i), .inc_j(inc_j), .inc_k(inc_k),
    .body_req(body_req), .busy(busy), .done(done), .body_cnt(body_cnt)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Datapath loop counters: clear/increment on strobes, z = limit > count
  int lim_i = 0, lim_j = 0, lim_k = 0;
  int ci = 0, cj = 0, ck = 0;
  always @(posedge Clk) begin
    if (rst_i) ci <= 0; else if (inc_i) ci <= ci + 1;
    if (rst_j) cj <= 0; else if (inc_j) cj <= cj + 1;
    if (rst_k) ck <= 0; else if (inc_k) ck <= ck + 1;
  end
  assign z_i = (lim_i > ci);
  assign z_j = (lim_j > cj);
  assign z_k = (lim_k > ck);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: body_cnt after each handshake, and per-run totals at done
  typedef struct {
    int n;
    int ii;
    int ij;
    int ik;
  } run_exp_t;
  int       body_q[$];
  run_exp_t exp_q[$];

  // Ack responder: tied high, or a random 0..5 cycle delay per body
  bit ack_tied = 1'b0;
  int ack_wait = 0;
  initial forever begin
    @(negedge Clk);
    if (ack_tied) body_ack = 1'b1;
    else if (body_req) begin
      if (ack_wait == 0) body_ack = 1'b1;
      else begin
        body_ack = 1'b0;
        ack_wait--;
      end
    end else begin
      body_ack = 1'b0;
      ack_wait = $urandom_range(0, 5);
    end
  end

  // Monitor: pops expectations when a body completes or a run ends
  bit pend = 1'b0;
  int t_ii = 0, t_ij = 0, t_ik = 0, t_coll = 0;
  initial forever begin
    @(negedge Clk);
    #1;
    if (RST) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (body_q.size() == 0) chk("unexpected_body", 1, 0);
        else chk("body_cnt_after_ack", int'(body_cnt), body_q.pop_front());
      end
      pend = body_req && body_ack && !abort;
      if (busy) begin
        t_ii += int'(inc_i);
        t_ij += int'(inc_j);
        t_ik += int'(inc_k);
        if ((inc_i && rst_i) || (inc_j && rst_j) || (inc_k && rst_k)) t_coll++;
      end
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          run_exp_t r;
          r = exp_q.pop_front();
          chk("done_body_cnt", int'(body_cnt), r.n % (1 << CNT_W));
          chk("inc_i_pulses", t_ii, r.ii);
          chk("inc_j_pulses", t_ij, r.ij);
          chk("inc_k_pulses", t_ik, r.ik);
          chk("bodies_outstanding", body_q.size(), 0);
          chk("inc_rst_collision", t_coll, 0);
        end
      end
      if (!busy) begin
        t_ii = 0; t_ij = 0; t_ik = 0; t_coll = 0;
      end
    end
  end

  // Load the reference model's expectations for one complete run
  task automatic expect_run(input int li, input int lj, input int lk);
    run_exp_t r;
    r.n  = li * lj * lk;
    r.ii = li;
    r.ij = li * lj;
    r.ik = li * lj * lk;
    for (int b = 1; b <= r.n; b++) body_q.push_back(b % (1 << CNT_W));
    exp_q.push_back(r);
  endtask

  // One full run; req_lat/done_lat are edges after the start edge (-1 = skip)
  task automatic run(input int li, input int lj, input int lk, input bit tied,
                     input bit mid_start, input bit done_start,
                     input int req_lat, input int done_lat);
    int s;
    int first_req;
    int done_at;
    lim_i = li; lim_j = lj; lim_k = lk;
    ack_tied = tied;
    expect_run(li, lj, lk);
    @(negedge Clk);
    start = 1'b1;
    s = cyc + 1;
    first_req = -1;
    done_at = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge Clk);
      start = mid_start && (cyc - s == 7);
      #1;
      if (body_req && first_req < 0) first_req = cyc - s;
      if (done) begin
        done_at = cyc - s;
        break;
      end
    end
    if (done_at < 0) chk("run_timeout", 0, 1);
    if (req_lat >= 0) chk("first_body_req_latency", first_req, req_lat);
    if (done_lat >= 0) chk("done_latency", done_at, done_lat);
    if (done_start) start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    #1;
    chk("done_single_cycle", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    @(negedge Clk);
    #1;
    chk("still_idle", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_body_cnt", int'(body_cnt), 0);
    chk("reset_strobes", int'({rst_i, rst_j, rst_k, inc_i, inc_j, inc_k, body_req, done}), 0);
    @(negedge Clk);
    RST = 1'b0;

    // Single iteration with tied ack: fixed latencies
    run(1, 1, 1, 1'b1, 1'b0, 1'b0, 5, 15);
    // 2x3x2 with random ack delays, start pulsed in the DONE cycle
    run(2, 3, 2, 1'b0, 1'b0, 1'b1, -1, -1);
    // Empty J loop: I still walks, no bodies
    run(3, 0, 4, 1'b0, 1'b0, 1'b0, -1, -1);
    // Empty I loop: straight to DONE
    run(0, 2, 2, 1'b0, 1'b0, 1'b0, -1, 3);

    // Abort in BODY with ack in the same cycle
    lim_i = 2; lim_j = 2; lim_k = 2;
    ack_tied = 1'b1;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (body_req) begin
        abort = 1'b1;
        break;
      end
    end
    chk("abort_reached_body", int'(body_req), 1);
    @(negedge Clk);
    abort = 1'b0;
    #1;
    chk("abort_idle", int'(busy), 0);
    chk("abort_body_cnt_held", int'(body_cnt), 0);
    chk("abort_no_done", int'(done), 0);
    chk("abort_no_strobes", int'({rst_i, rst_j, rst_k, inc_i, inc_j, inc_k, body_req}), 0);
    @(negedge Clk);
    #1;
    chk("abort_no_late_done", int'(done), 0);

    // Reset in a WAIT that follows an inc_k, several bodies into a run
    lim_i = 2; lim_j = 2; lim_k = 2;
    ack_tied = 1'b1;
    expect_run(2, 2, 2);
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clk);
      if (inc_k && body_cnt >= CNT_W'(3)) break;
    end
    chk("pre_reset_progress", int'(body_cnt >= CNT_W'(3)), 1);
    @(negedge Clk);
    RST = 1'b1;
    body_q.delete();
    exp_q.delete();
    #1;
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_body_cnt", int'(body_cnt), 0);
    chk("mid_reset_outputs", int'({rst_i, rst_j, rst_k, inc_i, inc_j, inc_k, body_req, done}), 0);
    @(negedge Clk);
    RST = 1'b0;
    // Full run afterwards, with a start pulse while busy
    run(2, 2, 3, 1'b0, 1'b1, 1'b0, -1, -1);

    // Randomized limits and ack behaviour
    for (int r = 0; r < 8; r++) begin
      run($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          -1, -1);
    end

    chk("final_body_q_empty", body_q.size(), 0);
    chk("final_exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
